sparse_gf2_block_mult: RTL and testbench
========================================

# sparse_gf2_block_mult

Parametrised GF(2) sparse block-matrix multiplier for the LDPC encoder datapath. It consumes a frame of `IN_LEN` WIDTH-bit block words and emits `OUT_LEN` block words. Output row r is the XOR of every input column c selected by a compile-time sparsity mask, with an optional per-entry circulant rotation. It replaces the fixed-matrix `sparse_mult_by_*` blocks: the default parameters reproduce the single-row E multiply, which passes through the last of 11 input words.

## Interface
Parameters:
- `WIDTH`, 96: block word width (bits).
- `IN_LEN`, 11: input words per frame (≥1).
- `OUT_LEN`, 1: output words per frame (≥1).
- `MASK`, `[OUT_LEN*IN_LEN-1:0]`, default only bit 10 set: bit `r*IN_LEN+c` set means column c contributes to row r.
- `SHIFT`, `[OUT_LEN*IN_LEN*$clog2(WIDTH)-1:0]`, default 0: rotate-left amount per (r,c) entry, same index order as `MASK`.

Ports:
- `i_clock`, in, 1: clock.
- `i_reset`, in, 1: reset. Synchronous, active-high.
- `i_input_data`, in, WIDTH: input block word.
- `i_input_valid`, in, 1: input word valid.
- `o_input_ready`, out, 1: block accepts an input word.
- `o_output_data`, out, WIDTH: output block word, row order 0..OUT_LEN-1.
- `o_output_valid`, out, 1: output word valid.
- `i_output_ready`, in, 1: downstream accepts an output word.

## Operation
- Input side:
  - Column counter `col` runs 0..IN_LEN-1.
  - Accumulators `acc[0..OUT_LEN-1]`.
  - An input word is accepted when valid && ready. On accept, for every r with `MASK[r*IN_LEN+col]`: `acc[r] ^= rot(i_input_data, SHIFT[r,col])`.
  - `col` increments and wraps to 0 after IN_LEN-1.
- Frame close: on accepting the word at `col==IN_LEN-1`, the final accumulator values, including that word's contribution, are copied into output buffer `obuf`. In the same cycle `acc` clears, `out_busy` sets and `row` is set to 0.
- Output side:
  - `o_output_valid = out_busy`, `o_output_data = obuf[row]`.
  - On valid && ready, `row` increments. When the handshake occurs at `row==OUT_LEN-1`, `out_busy` clears.
- Backpressure: `o_input_ready = !i_reset && !(col==IN_LEN-1 && out_busy && !(i_output_ready && row==OUT_LEN-1))`.
  - Columns 0..IN_LEN-2 of the next frame are always accepted while the previous frame drains.
  - Only the closing word stalls.
- Unselected columns are still consumed. A frame whose column set in `MASK` is empty for a row outputs 0 for that row.
- Arithmetic is pure XOR with no carries. `rot(x,s) = (x<<s)|(x>>(WIDTH-s))`, with s=0 giving identity.

## Timing
- Reset values, held while `i_reset` is high: `o_output_valid=0`, `o_output_data=0`, `o_input_ready=0`, `col=0`, `row=0`, `out_busy=0`, `acc` all zero.
- Reset mid-frame discards any partial `acc` and any undrained `obuf` contents.
- Latency: if the closing word is accepted at edge N, row 0 is valid after edge N (visible in cycle N+1). With `i_output_ready` held high, row r is presented in cycle N+1+r.
- Throughput: one input word per cycle sustained when OUT_LEN ≤ IN_LEN and downstream is always ready.
- Simultaneous closing-word accept and final-row drain in the same cycle: both take effect. `obuf` is reloaded and `out_busy` stays 1, giving no bubble.
- `o_output_data` is stable while `o_output_valid && !i_output_ready`.
- The input path ignores `i_input_data` when `i_input_valid` is 0.

## Configuration
- `SPARSE_GF2_ROTATE_EN` defined:
  - `SHIFT` is honoured through one barrel rotator per output row.
  - Each rotator uses a `$clog2(WIDTH)`-stage mux. No pipelining is added, so latency is unchanged.
- `SPARSE_GF2_ROTATE_EN` undefined:
  - `SHIFT` is ignored and `rot` is the identity.
  - No rotator logic is generated.

## Test plan
- Idle: reset, then `i_output_ready=1` for 100 cycles with no input → zero outputs; `o_output_valid` is never 1.
- Default params: 11 words whose last word is {67108896,65536,134217792} (high,mid,low 32-bit lanes) → exactly one output, equal to {67108896,65536,134217792}. An all-zero frame → one output of 0.
- IN_LEN=3, OUT_LEN=2, MASK row0={c0,c1}, row1={c2}; inputs 5,3,9 → outputs 6 then 9, in consecutive cycles.
- Backpressure: hold `i_output_ready=0` and stream two default frames back-to-back.
  - `o_input_ready` drops only at the second frame's 11th word.
  - After raising `i_output_ready`, 2 outputs arrive in order and none are lost or duplicated.
- Rotate (macro defined): WIDTH=8, IN_LEN=1, OUT_LEN=1, MASK=1, SHIFT=1; input 0x81 → 0x03. With the macro undefined, the same input → 0x81.
- Reset mid-frame: send 5 words, assert reset for 1 cycle, then send a full frame → one output reflecting only the post-reset frame.

Source files
------------

// File: rtl/sparse_gf2_block_mult.sv
// GF(2) sparse block-matrix multiplier: XOR-accumulates masked input columns per output row.
// Optional per-entry circulant rotation enabled by defining SPARSE_GF2_ROTATE_EN.
module sparse_gf2_block_mult #(
    parameter int unsigned WIDTH   = 96,
    parameter int unsigned IN_LEN  = 11,
    parameter int unsigned OUT_LEN = 1,
    parameter logic [OUT_LEN*IN_LEN-1:0] MASK = (OUT_LEN*IN_LEN)'(1) << 10,
    parameter logic [OUT_LEN*IN_LEN*$clog2(WIDTH)-1:0] SHIFT = '0
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_input_data,
    input  logic             i_input_valid,
    output logic             o_input_ready,
    output logic [WIDTH-1:0] o_output_data,
    output logic             o_output_valid,
    input  logic             i_output_ready
);

    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned CW = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam int unsigned RW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IN_LEN - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(OUT_LEN - 1);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic             out_busy;
    logic [WIDTH-1:0] acc      [OUT_LEN];
    logic [WIDTH-1:0] acc_next [OUT_LEN];
    logic [WIDTH-1:0] obuf     [OUT_LEN];
    logic             last_col;
    logic             last_row;
    logic             in_fire;
    logic             out_fire;

    assign last_col = (col == COL_LAST);
    assign last_row = (row == ROW_LAST);

    // Only the closing word stalls, and only when the final row cannot drain this cycle.
    assign o_input_ready  = !i_reset && !(last_col && out_busy && !(i_output_ready && last_row));
    assign in_fire        = i_input_valid && o_input_ready;
    assign out_fire       = out_busy && i_output_ready;
    assign o_output_valid = out_busy;
    assign o_output_data  = obuf[row];

`ifdef SPARSE_GF2_ROTATE_EN
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input logic [SW-1:0] amt);
        logic [WIDTH-1:0] y;
        int unsigned      k;
        y = x;
        for (int unsigned s = 0; s < SW; s++) begin
            k = (32'd1 << s) % WIDTH;
            if (amt[s] && k != 0)
                y = (y << k) | (y >> (WIDTH - k));
        end
        return y;
    endfunction
`else
    logic unused_shift;
    assign unused_shift = ^SHIFT;
`endif

    // The column's shift amount is muxed first so each row needs a single rotator.
    always_comb begin
        for (int unsigned r = 0; r < OUT_LEN; r++) begin
            logic          sel;
            logic [SW-1:0] amt;
            sel = 1'b0;
            amt = '0;
            for (int unsigned c = 0; c < IN_LEN; c++) begin
                if (col == CW'(c)) begin
                    sel = MASK[r*IN_LEN + c];
                    amt = SHIFT[(r*IN_LEN + c)*SW +: SW];
                end
            end
            acc_next[r] = acc[r];
            if (sel) begin
`ifdef SPARSE_GF2_ROTATE_EN
                acc_next[r] = acc[r] ^ rotl(i_input_data, amt);
`else
                acc_next[r] = acc[r] ^ i_input_data;
`endif
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            col      <= '0;
            row      <= '0;
            out_busy <= 1'b0;
            for (int unsigned r = 0; r < OUT_LEN; r++) begin
                acc[r]  <= '0;
                obuf[r] <= '0;
            end
        end else begin
            if (in_fire) begin
                col <= last_col ? '0 : col + CW'(1);
                for (int unsigned r = 0; r < OUT_LEN; r++) begin
                    acc[r] <= last_col ? '0 : acc_next[r];
                    if (last_col)
                        obuf[r] <= acc_next[r];
                end
            end
            // A close can coincide only with the final-row drain, so reload wins without a bubble.
            if (in_fire && last_col) begin
                out_busy <= 1'b1;
                row      <= '0;
            end else if (out_fire) begin
                if (last_row) begin
                    out_busy <= 1'b0;
                    row      <= '0;
                end else begin
                    row <= row + RW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sparse_gf2_block_mult.sv
// Directed self-checking bench for sparse_gf2_block_mult: default, 3x2 and rotate configurations.
module tb_sparse_gf2_block_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [95:0] din0, dout0;
    logic        vin0, rdy_in0, vout0, rdy_out0;
    logic [7:0]  din1, dout1;
    logic        vin1, rdy_in1, vout1, rdy_out1;
    logic [7:0]  din2, dout2;
    logic        vin2, rdy_in2, vout2, rdy_out2;

    int checks   = 0;
    int failures = 0;

    logic [95:0] q0[$];
    bit          seen_valid0;

`ifdef SPARSE_GF2_ROTATE_EN
    localparam logic [7:0] ROT_EXP = 8'h03;
`else
    localparam logic [7:0] ROT_EXP = 8'h81;
`endif

    localparam logic [95:0] A_WORD = {32'd67108896, 32'd65536, 32'd134217792};
    localparam logic [95:0] B1     = 96'h0123_4567_89ab_cdef_1357_9bdf;
    localparam logic [95:0] B2     = 96'hfedc_ba98_7654_3210_2468_ace0;
    localparam logic [95:0] C_WORD = 96'h5555_0000_aaaa_ffff_1234_8765;
    localparam logic [95:0] FILL   = 96'hdead_beef_cafe_f00d_0bad_c0de;

    sparse_gf2_block_mult dut0 (
        .i_clock(clk), .i_reset(rst),
        .i_input_data(din0), .i_input_valid(vin0), .o_input_ready(rdy_in0),
        .o_output_data(dout0), .o_output_valid(vout0), .i_output_ready(rdy_out0)
    );

    sparse_gf2_block_mult #(
        .WIDTH(8), .IN_LEN(3), .OUT_LEN(2), .MASK(6'b100011)
    ) dut1 (
        .i_clock(clk), .i_reset(rst),
        .i_input_data(din1), .i_input_valid(vin1), .o_input_ready(rdy_in1),
        .o_output_data(dout1), .o_output_valid(vout1), .i_output_ready(rdy_out1)
    );

    sparse_gf2_block_mult #(
        .WIDTH(8), .IN_LEN(1), .OUT_LEN(1), .MASK(1'b1), .SHIFT(3'd1)
    ) dut2 (
        .i_clock(clk), .i_reset(rst),
        .i_input_data(din2), .i_input_valid(vin2), .o_input_ready(rdy_in2),
        .o_output_data(dout2), .o_output_valid(vout2), .i_output_ready(rdy_out2)
    );

    // Records every output handshake of dut0, sampled half a cycle before the edge that takes it.
    always @(negedge clk) begin
        if (!rst) begin
            if (vout0) seen_valid0 = 1'b1;
            if (vout0 && rdy_out0) q0.push_back(dout0);
        end
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send0(input logic [95:0] w);
        int n;
        n = 0;
        din0 = w;
        vin0 = 1'b1;
        @(negedge clk);
        while (!rdy_in0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_in0) chk("send0_timeout", 96'(rdy_in0), 96'd1);
        @(posedge clk);
        #1;
        vin0 = 1'b0;
    endtask

    task automatic send1(input logic [7:0] w);
        int n;
        n = 0;
        din1 = w;
        vin1 = 1'b1;
        @(negedge clk);
        while (!rdy_in1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_in1) chk("send1_timeout", 96'(rdy_in1), 96'd1);
        @(posedge clk);
        #1;
        vin1 = 1'b0;
    endtask

    task automatic send2(input logic [7:0] w);
        int n;
        n = 0;
        din2 = w;
        vin2 = 1'b1;
        @(negedge clk);
        while (!rdy_in2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_in2) chk("send2_timeout", 96'(rdy_in2), 96'd1);
        @(posedge clk);
        #1;
        vin2 = 1'b0;
    endtask

    task automatic send_frame0(input logic [95:0] last, input logic [95:0] fill);
        for (int i = 0; i < 10; i++) send0(fill ^ 96'(i));
        send0(last);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1'b1;
        din0 = '0; vin0 = 1'b0; rdy_out0 = 1'b1;
        din1 = '0; vin1 = 1'b0; rdy_out1 = 1'b1;
        din2 = '0; vin2 = 1'b0; rdy_out2 = 1'b1;
        seen_valid0 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid0", 96'(vout0), 96'd0);
        chk("reset_data0", dout0, 96'd0);
        chk("reset_ready0", 96'(rdy_in0), 96'd0);
        chk("reset_valid1", 96'(vout1), 96'd0);
        chk("reset_data1", 96'(dout1), 96'd0);
        chk("reset_ready1", 96'(rdy_in1), 96'd0);
        chk("reset_valid2", 96'(vout2), 96'd0);
        rst = 1'b0;

        // Idle: no input, nothing emitted
        q0.delete();
        seen_valid0 = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("idle_count", 96'(q0.size()), 96'd0);
        chk("idle_valid_seen", 96'(seen_valid0), 96'd0);
        chk("idle_ready", 96'(rdy_in0), 96'd1);

        // Default params: only the 11th word passes through, visible right after the closing edge
        q0.delete();
        send_frame0(A_WORD, FILL);
        chk("default_latency_valid", 96'(vout0), 96'd1);
        chk("default_latency_data", dout0, A_WORD);
        repeat (3) @(posedge clk);
        #1;
        chk("default_count", 96'(q0.size()), 96'd1);
        chk("default_data", q0[0], A_WORD);
        chk("default_valid_drop", 96'(vout0), 96'd0);

        q0.delete();
        send_frame0(96'd0, 96'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("zero_count", 96'(q0.size()), 96'd1);
        chk("zero_data", q0[0], 96'd0);

        // 3x2: row0 = 5^3 = 6, row1 = 9, consecutive cycles
        send1(8'd5);
        send1(8'd3);
        send1(8'd9);
        chk("m32_row0_valid", 96'(vout1), 96'd1);
        chk("m32_row0_data", 96'(dout1), 96'd6);
        @(posedge clk);
        #1;
        chk("m32_row1_valid", 96'(vout1), 96'd1);
        chk("m32_row1_data", 96'(dout1), 96'd9);
        @(posedge clk);
        #1;
        chk("m32_done", 96'(vout1), 96'd0);

        // Rotate-by-one entry (identity when rotation is compiled out)
        send2(8'h81);
        chk("rot_valid", 96'(vout2), 96'd1);
        chk("rot_data", 96'(dout2), 96'(ROT_EXP));
        @(posedge clk);
        #1;
        chk("rot_done", 96'(vout2), 96'd0);

        // Backpressure: two frames back-to-back with downstream stalled
        q0.delete();
        rdy_out0 = 1'b0;
        for (int i = 0; i < 22; i++) begin
            din0 = (i == 10) ? B1 : (i == 21) ? B2 : (FILL ^ 96'(i * 3 + 1));
            vin0 = 1'b1;
            @(negedge clk);
            chk($sformatf("bp_ready_w%0d", i), 96'(rdy_in0), (i == 21) ? 96'd0 : 96'd1);
            if (i < 21) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_stall_ready", 96'(rdy_in0), 96'd0);
            chk("bp_hold_valid", 96'(vout0), 96'd1);
            chk("bp_hold_data", dout0, B1);
        end
        rdy_out0 = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 96'(rdy_in0), 96'd1);
        @(posedge clk);
        #1;
        vin0 = 1'b0;
        chk("bp_nobubble_valid", 96'(vout0), 96'd1);
        chk("bp_nobubble_data", dout0, B2);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_count", 96'(q0.size()), 96'd2);
        chk("bp_first", q0[0], B1);
        chk("bp_second", q0[1], B2);

        // Reset mid-frame discards partial state on both dut0 and dut1
        q0.delete();
        for (int i = 0; i < 5; i++) send0(C_WORD ^ 96'(i + 1));
        send1(8'd7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame0(C_WORD, FILL);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_count", 96'(q0.size()), 96'd1);
        chk("rst_mid_data", q0[0], C_WORD);
        send1(8'd5);
        send1(8'd3);
        send1(8'd9);
        chk("rst_mid_m32_row0", 96'(dout1), 96'd6);
        @(posedge clk);
        #1;
        chk("rst_mid_m32_row1", 96'(dout1), 96'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
